// File: rtl/pipelined_mux_nto1.sv
// pipelined_mux_nto1
// Registered N-to-1 selector for the pipeline datapath. It picks one of
// NInputs packed operand buses, registers the result with a valid bit, and
// honours stall (Enable=0) and bubble insertion (Flush=1).
// A selector value with no matching input yields all-zero data.
// Optional feature macro: MUX_SEL_ERR_EN adds the sticky Sel_Error output.
// Legal NInputs range is 2..16. SelBits is derived and should not be overridden.
module pipelined_mux_nto1 #(
  parameter int NBits   = 32,
  parameter int NInputs = 3,
  parameter int SelBits = $clog2(NInputs)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       Enable,
  input  logic                       Flush,
  input  logic                       In_Valid,
  input  logic [SelBits-1:0]         Selector,
  input  logic [NInputs*NBits-1:0]   MUX_Data,
  output logic [NBits-1:0]           MUX_Output,
  output logic                       Out_Valid
`ifdef MUX_SEL_ERR_EN
  ,
  output logic                       Sel_Error
`endif
);

  // Unpacked view of the packed data bus: word k is MUX_Data[k*NBits +: NBits]
  logic [NBits-1:0] in_word [NInputs];

  genvar gi;
  generate
    for (gi = 0; gi < NInputs; gi++) begin : g_unpack
      assign in_word[gi] = MUX_Data[gi*NBits +: NBits];
    end
  endgenerate

  logic [NBits-1:0] sel_data;
`ifdef MUX_SEL_ERR_EN
  logic             sel_hit;
`endif

  // Combinational pick: defaults to zero so unmatched selectors give 0 and no latch forms.
  // When NInputs is a power of two every selector value matches some input.
  always_comb begin
    sel_data = '0;
`ifdef MUX_SEL_ERR_EN
    sel_hit  = 1'b0;
`endif
    for (int k = 0; k < NInputs; k++) begin
      if (Selector == SelBits'(k)) begin
        sel_data = in_word[k];
`ifdef MUX_SEL_ERR_EN
        sel_hit  = 1'b1;
`endif
      end
    end
  end

  logic [NBits-1:0] mux_output_reg;
  logic             out_valid_reg;

  // Output stage: async clear, then flush beats enable, and Enable=0 holds.
  // Data is loaded even for invalid slots, because consumers qualify it with Out_Valid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mux_output_reg <= '0;
      out_valid_reg  <= 1'b0;
    end else if (Flush) begin
      mux_output_reg <= '0;
      out_valid_reg  <= 1'b0;
    end else if (Enable) begin
      mux_output_reg <= sel_data;
      out_valid_reg  <= In_Valid;
    end
  end

  assign MUX_Output = mux_output_reg;
  assign Out_Valid  = out_valid_reg;

`ifdef MUX_SEL_ERR_EN
  logic sel_error_reg;

  // Sticky decode-fault flag. It sets when a real instruction advances with an unmatched selector.
  // Only reset clears it. A flush leaves it untouched.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sel_error_reg <= 1'b0;
    end else if (Enable && In_Valid && !sel_hit) begin
      sel_error_reg <= 1'b1;
    end
  end

  assign Sel_Error = sel_error_reg;
`endif

endmodule

// File: tb/tb_pipelined_mux_nto1.sv
// Testbench for pipelined_mux_nto1 (NBits=32, NInputs=3).
// It checks a reference model every cycle and also checks literal expectations for the directed vectors.
// It covers Sel_Error as well when MUX_SEL_ERR_EN is defined.
module tb_pipelined_mux_nto1;
  localparam int NB = 32;
  localparam int NI = 3;
  localparam int SB = $clog2(NI);

  logic              clk = 1'b0;
  logic              reset;
  logic              Enable;
  logic              Flush;
  logic              In_Valid;
  logic [SB-1:0]     Selector;
  logic [NI*NB-1:0]  MUX_Data;
  logic [NB-1:0]     MUX_Output;
  logic              Out_Valid;
  logic              Sel_Error;
  logic [NB-1:0]     data_word [NI];

  int checks = 0;
  int errors = 0;
  bit run_cmp = 1'b0;

  // Reference model state
  logic [NB-1:0] mdl_out;
  logic          mdl_valid;
  logic          mdl_err;

  always_comb begin
    MUX_Data = '0;
    for (int k = 0; k < NI; k++) MUX_Data[k*NB +: NB] = data_word[k];
  end

  pipelined_mux_nto1 #(.NBits(NB), .NInputs(NI)) dut (
    .clk        (clk),
    .reset      (reset),
    .Enable     (Enable),
    .Flush      (Flush),
    .In_Valid   (In_Valid),
    .Selector   (Selector),
    .MUX_Data   (MUX_Data),
    .MUX_Output (MUX_Output),
`ifdef MUX_SEL_ERR_EN
    .Sel_Error  (Sel_Error),
`endif
    .Out_Valid  (Out_Valid)
  );

`ifndef MUX_SEL_ERR_EN
  assign Sel_Error = 1'b0;
`endif

  always #5 clk = ~clk;

  // Behavioural model: decide what the stage must hold after each edge
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mdl_out = '0; mdl_valid = 1'b0; mdl_err = 1'b0;
    end else if (Flush) begin
      mdl_out = '0; mdl_valid = 1'b0;
    end else if (Enable) begin
      if (int'(Selector) < NI) mdl_out = data_word[int'(Selector)];
      else                     mdl_out = '0;
      mdl_valid = In_Valid;
      if (In_Valid && int'(Selector) >= NI) mdl_err = 1'b1;
    end
  end

  task automatic chk(input string name, input logic [NB-1:0] act, input logic [NB-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, 2 time units after each rising edge
  always begin
    @(posedge clk);
    #2;
    if (run_cmp) begin
      chk("model_data", MUX_Output, mdl_out);
      chk("model_valid", {31'd0, Out_Valid}, {31'd0, mdl_valid});
`ifdef MUX_SEL_ERR_EN
      chk("model_err", {31'd0, Sel_Error}, {31'd0, mdl_err});
`endif
    end
  end

  task automatic drive(input logic en, input logic fl, input logic iv, input logic [SB-1:0] sel);
    @(negedge clk);
    Enable = en; Flush = fl; In_Valid = iv; Selector = sel;
  endtask

  // Wait for the edge that consumes the driven inputs, then settle
  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  task automatic set_data(input logic [NB-1:0] a, input logic [NB-1:0] b, input logic [NB-1:0] c);
    data_word[0] = a; data_word[1] = b; data_word[2] = c;
  endtask

  logic [NB-1:0] sweep_exp [3];

  initial begin
    sweep_exp[0] = 32'h11111111; sweep_exp[1] = 32'h22222222; sweep_exp[2] = 32'h33333333;
    reset = 1'b0; Enable = 1'b1; Flush = 1'b0; In_Valid = 1'b1; Selector = 2'd2;
    set_data(32'hA5A5A5A5, 32'h5A5A5A5A, 32'hCAFEF00D);
    #1;
    run_cmp = 1'b1;

    // Reset held with active inputs
    for (int i = 0; i < 3; i++) begin
      after_edge();
      Selector = SB'(i);
      chk("reset_data", MUX_Output, 32'h0);
      chk("reset_valid", {31'd0, Out_Valid}, 32'd0);
      $display("reset cycle %0d: out=%h valid=%b", i, MUX_Output, Out_Valid);
    end

    // Release reset, then do the first load
    @(negedge clk);
    reset = 1'b1;
    set_data(32'h0, 32'hDEADBEEF, 32'h0);
    drive(1'b1, 1'b0, 1'b1, 2'd1);
    after_edge();
    chk("first_load", MUX_Output, 32'hDEADBEEF);
    chk("first_valid", {31'd0, Out_Valid}, 32'd1);
    $display("first load: out=%h valid=%b", MUX_Output, Out_Valid);

    // Sweep through the legal selectors
    set_data(32'h11111111, 32'h22222222, 32'h33333333);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b1, SB'(i));
      after_edge();
      chk("sweep_data", MUX_Output, sweep_exp[i]);
      chk("sweep_valid", {31'd0, Out_Valid}, 32'd1);
      $display("sweep sel=%0d: out=%h valid=%b", i, MUX_Output, Out_Valid);
    end

    // Stall with changing inputs
    drive(1'b1, 1'b0, 1'b1, 2'd1);
    after_edge();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, i[0], SB'(i % 3));
      set_data(32'h1000 + i, 32'h2000 + i, 32'h3000 + i);
      after_edge();
      chk("stall_data", MUX_Output, 32'h22222222);
      chk("stall_valid", {31'd0, Out_Valid}, 32'd1);
      $display("stall cycle %0d: out=%h valid=%b", i, MUX_Output, Out_Valid);
    end
    set_data(32'h11111111, 32'h22222222, 32'h33333333);
    drive(1'b1, 1'b0, 1'b1, 2'd2);
    after_edge();
    chk("resume_data", MUX_Output, 32'h33333333);
    $display("resume: out=%h valid=%b", MUX_Output, Out_Valid);

    // Flush takes priority over the stall
    drive(1'b0, 1'b1, 1'b1, 2'd2);
    after_edge();
    chk("flush_data", MUX_Output, 32'h0);
    chk("flush_valid", {31'd0, Out_Valid}, 32'd0);
    $display("flush (Enable=0): out=%h valid=%b", MUX_Output, Out_Valid);

    // An invalid slot still loads data
    drive(1'b1, 1'b0, 1'b0, 2'd0);
    after_edge();
    chk("bubble_data", MUX_Output, 32'h11111111);
    chk("bubble_valid", {31'd0, Out_Valid}, 32'd0);
    $display("In_Valid=0 load: out=%h valid=%b", MUX_Output, Out_Valid);

    // Out-of-range selector on an invalid slot must not raise the flag
    drive(1'b1, 1'b0, 1'b0, 2'd3);
    after_edge();
    chk("oor_bubble_data", MUX_Output, 32'h0);
    chk("oor_bubble_err", {31'd0, Sel_Error}, 32'd0);
    $display("out-of-range, invalid: out=%h valid=%b err=%b", MUX_Output, Out_Valid, Sel_Error);

    // Out-of-range selector on a real instruction
    drive(1'b1, 1'b0, 1'b1, 2'd3);
    after_edge();
    chk("oor_data", MUX_Output, 32'h0);
    chk("oor_valid", {31'd0, Out_Valid}, 32'd1);
`ifdef MUX_SEL_ERR_EN
    chk("oor_err", {31'd0, Sel_Error}, 32'd1);
`endif
    $display("out-of-range, valid: out=%h valid=%b err=%b", MUX_Output, Out_Valid, Sel_Error);

    // The flag survives a flush and later legal selects
    drive(1'b1, 1'b1, 1'b1, 2'd0);
    after_edge();
    chk("flush_en_valid", {31'd0, Out_Valid}, 32'd0);
`ifdef MUX_SEL_ERR_EN
    chk("err_after_flush", {31'd0, Sel_Error}, 32'd1);
`endif
    drive(1'b1, 1'b0, 1'b1, 2'd2);
    after_edge();
    chk("legal_after_oor", MUX_Output, 32'h33333333);
`ifdef MUX_SEL_ERR_EN
    chk("err_after_legal", {31'd0, Sel_Error}, 32'd1);
`endif
    $display("flush + legal select: out=%h valid=%b err=%b", MUX_Output, Out_Valid, Sel_Error);

    // Reset asserted between clock edges
    @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("async_data", MUX_Output, 32'h0);
    chk("async_valid", {31'd0, Out_Valid}, 32'd0);
    chk("async_err", {31'd0, Sel_Error}, 32'd0);
    $display("async reset: out=%h valid=%b err=%b", MUX_Output, Out_Valid, Sel_Error);
    @(negedge clk);
    reset = 1'b1;
    drive(1'b1, 1'b0, 1'b1, 2'd1);
    after_edge();
    chk("post_reset_load", MUX_Output, 32'h22222222);
    $display("post-reset load: out=%h valid=%b", MUX_Output, Out_Valid);

    // Back-to-back stream with mixed controls; the per-cycle model check covers it
    for (int i = 0; i < 12; i++) begin
      drive(i % 4 != 3, i % 5 == 4, i[0], SB'(i % 4));
      set_data(32'h100 * i, 32'h200 * i + 1, 32'h300 * i + 2);
      after_edge();
      $display("stream %0d: out=%h valid=%b err=%b", i, MUX_Output, Out_Valid, Sel_Error);
    end

    run_cmp = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
